sync_fifo_param: RTL and testbench



---
 rtl/sync_fifo_param.sv | 122 ++++++++++++
 tb/tb_sync_fifo_param.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock parametrised FIFO with an occupancy count,
// registered almost-full/almost-empty flags and one-cycle overflow/underflow
// pulses.
//
// Optional build macro SYNC_FIFO_FWFT_EN selects first-word-fall-through
// reads. Without it, reads have one cycle of registered latency.
//
// Ports:
//   clock        : single clock, rising edge
//   reset        : asynchronous, active-high reset
//   write_enable : push request; accepted when the FIFO is not full
//   write_data   : push data (DATA_W bits)
//   read_enable  : pop request (an acknowledge in FWFT mode); accepted when
//                  the FIFO is not empty
//   read_data    : popped word (in FWFT mode, the head word)
//   read_valid   : read_data holds a valid word
//   full, empty  : count == DEPTH, count == 0
//   almost_full  : count >= AF_THRESH
//   almost_empty : count <= AE_THRESH
//   count        : occupancy, 0..DEPTH
//   overflow     : one-cycle pulse after a rejected write
//   underflow    : one-cycle pulse after a rejected read
//
// Handshake: a push is accepted on a rising edge when write_enable=1 and
// full=0. A pop is accepted on a rising edge when read_enable=1 and empty=0.
// Both decisions use the registered flags only, so the flags never depend
// combinationally on the inputs.
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         write_enable,
  input  logic [DATA_W-1:0]            write_data,
  input  logic                         read_enable,
  output logic [DATA_W-1:0]            read_data,
  output logic                         read_valid,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] AF_T  = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_T  = CNT_W'(AE_THRESH);
  localparam logic [CNT_W-1:0] FULL_T = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wptr, rptr;
  logic [ADDR_W:0]   wptr_n, rptr_n;
  logic [CNT_W-1:0]  count_n;
  logic              wr_acc, rd_acc;

  assign wr_acc = write_enable && !full;
  assign rd_acc = read_enable && !empty;

  // Pointers carry one extra bit, so their difference modulo 2*DEPTH is the
  // occupancy. Full (DEPTH) and empty (0) remain distinct values.
  always_comb begin
    wptr_n  = wptr + (ADDR_W+1)'(wr_acc);
    rptr_n  = rptr + (ADDR_W+1)'(rd_acc);
    count_n = CNT_W'(wptr_n - rptr_n);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wptr         <= wptr_n;
      rptr         <= rptr_n;
      count        <= count_n;
      full         <= (count_n == FULL_T);
      empty        <= (count_n == '0);
      almost_full  <= (count_n >= AF_T);
      almost_empty <= (count_n <= AE_T);
      overflow     <= write_enable && full;
      underflow    <= read_enable && empty;
    end
  end

  // Storage is not reset; only written locations are ever presented.
  always_ff @(posedge clock) begin
    if (wr_acc) mem[wptr[ADDR_W-1:0]] <= write_data;
  end

`ifdef SYNC_FIFO_FWFT_EN
  // The head word falls through. read_valid is the registered non-empty
  // flag. The data is forced to zero while empty, so the output never shows
  // an unwritten location.
  assign read_valid = !empty;
  assign read_data  = empty ? '0 : mem[rptr[ADDR_W-1:0]];
`else
  // Registered read: data appears one cycle after the accepted pop. The data
  // holds its last value when no pop is accepted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      read_valid <= 1'b0;
      read_data  <= '0;
    end else begin
      read_valid <= rd_acc;
      if (rd_acc) read_data <= mem[rptr[ADDR_W-1:0]];
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed bench for sync_fifo_param (DEPTH=8, AF=6, AE=2).
// The driver keeps a queue model of FIFO contents and pushes each word it
// expects to be popped onto exp_q. A negedge monitor compares read_data
// against exp_q whenever the DUT presents a popped word.
module tb_sync_fifo_param;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;

  logic              clock;
  logic              reset;
  logic              write_enable;
  logic [DATA_W-1:0] write_data;
  logic              read_enable;
  logic [DATA_W-1:0] read_data;
  logic              read_valid;
  logic              full, empty, almost_full, almost_empty;
  logic [3:0]        count;
  logic              overflow, underflow;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] mdl_q[$];
  logic [DATA_W-1:0] exp_word;

  sync_fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(6), .AE_THRESH(2)) dut (
    .clock(clock), .reset(reset),
    .write_enable(write_enable), .write_data(write_data),
    .read_enable(read_enable), .read_data(read_data), .read_valid(read_valid),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  // clock/reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: issue one cycle of stimulus, update the model, then return at
  // 1 time unit after the edge with the inputs idle
  task automatic step(input logic we, input logic [DATA_W-1:0] wd, input logic re);
    logic m_wr, m_rd;
    m_wr = we && (mdl_q.size() < DEPTH);
    m_rd = re && (mdl_q.size() > 0);
    write_enable = we;
    write_data   = wd;
    read_enable  = re;
    if (m_rd) exp_q.push_back(mdl_q.pop_front());
    if (m_wr) mdl_q.push_back(wd);
    @(posedge clock); #1;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    check("count_vs_model", 32'(count), 32'(mdl_q.size()));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_almost_empty"}, 32'(almost_empty), 32'd1);
    check({tag, "_full"}, 32'(full), 32'd0);
    check({tag, "_almost_full"}, 32'(almost_full), 32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_read_valid"}, 32'(read_valid), 32'd0);
    check({tag, "_read_data"}, 32'(read_data), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
    check({tag, "_underflow"}, 32'(underflow), 32'd0);
  endtask

  // monitor / scoreboard
  always @(negedge clock) begin
    if (!reset) begin
`ifdef SYNC_FIFO_FWFT_EN
      if (read_valid && read_enable) begin
`else
      if (read_valid) begin
`endif
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL read_data_unexpected: got %0h expected no word", read_data);
        end else begin
          exp_word = exp_q.pop_front();
          check("read_data", 32'(read_data), 32'(exp_word));
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    write_enable = 1'b0;
    write_data = '0;
    read_enable = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_state("reset");
    reset = 1'b0;
    idle(1);
    check_reset_state("idle");

    // Fill 0x11..0x18
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, DATA_W'(8'h10 + i), 1'b0);
      check("fill_almost_empty", 32'(almost_empty), 32'(i <= 2));
      check("fill_almost_full", 32'(almost_full), 32'(i >= 6));
      check("fill_full", 32'(full), 32'(i == 8));
      check("fill_empty", 32'(empty), 32'd0);
    end
    check("fill_count", 32'(count), 32'd8);

    // Write while full
    step(1'b1, 8'h99, 1'b0);
    check("ovf_pulse", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd8);
    idle(1);
    check("ovf_clear", 32'(overflow), 32'd0);

    // Drain
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_count", 32'(count), 32'd0);
    step(1'b0, '0, 1'b1);
    check("udf_pulse", 32'(underflow), 32'd1);
    check("udf_count", 32'(count), 32'd0);
    check("udf_read_valid", 32'(read_valid), 32'd0);
    idle(1);
    check("udf_clear", 32'(underflow), 32'd0);

    // Wrap-around: pointers pass 2*DEPTH
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) step(1'b1, DATA_W'(8'h40 + 16*r + i), 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
      idle(1);
      check("wrap_count", 32'(count), 32'd0);
      check("wrap_empty", 32'(empty), 32'd1);
    end

    // Simultaneous write and read while full
    for (int i = 0; i < 8; i++) step(1'b1, DATA_W'(8'hB0 + i), 1'b0);
    step(1'b1, 8'hEE, 1'b1);
    check("full_wr_rd_overflow", 32'(overflow), 32'd1);
    check("full_wr_rd_count", 32'(count), 32'd7);
    for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1);
    idle(1);

    // Simultaneous write and read while empty
    step(1'b1, 8'hA5, 1'b1);
    check("empty_wr_rd_underflow", 32'(underflow), 32'd1);
    check("empty_wr_rd_count", 32'(count), 32'd1);
    idle(1);
    step(1'b0, '0, 1'b1);
    idle(1);

    // Simultaneous write and read at count 4
    for (int i = 0; i < 4; i++) step(1'b1, DATA_W'(8'hC0 + i), 1'b0);
    step(1'b1, 8'hC4, 1'b1);
    check("mid_wr_rd_count", 32'(count), 32'd4);
    check("mid_wr_rd_flags", 32'({overflow, underflow}), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
    idle(2);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

`ifdef SYNC_FIFO_FWFT_EN
    // The head word falls through without read_enable
    step(1'b1, 8'h3C, 1'b0);
    check("fwft_read_valid", 32'(read_valid), 32'd1);
    check("fwft_read_data", 32'(read_data), 32'h3C);
    step(1'b0, '0, 1'b1);
    check("fwft_ack_empty", 32'(empty), 32'd1);
    check("fwft_ack_read_valid", 32'(read_valid), 32'd0);
    idle(1);
`endif

    // Asynchronous reset mid-stream at count 5
    for (int i = 0; i < 5; i++) step(1'b1, DATA_W'(8'hD0 + i), 1'b0);
    check("pre_reset_count", 32'(count), 32'd5);
    reset = 1'b1;
    #2;
    check_reset_state("async_reset");
    mdl_q.delete();
    exp_q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    idle(1);
    check("post_reset_count", 32'(count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
